// File: rtl/traffic_light_fsm.sv
// Highway / farm-road traffic light controller.
// The highway stays green until a farm-road car is seen and the long timer has
// expired. The farm road then gets green until its car leaves or the long timer
// expires. Each change of state pulses st for one cycle, which clears both
// external interval timers. All outputs come straight from flops.
module traffic_light_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic       c,
   input  logic       tl,
   input  logic       ts,
   output logic       st,
   output logic [1:0] hl,
   output logic [1:0] fl
);

   localparam logic [1:0] LIGHT_GREEN  = 2'b00;
   localparam logic [1:0] LIGHT_YELLOW = 2'b01;
   localparam logic [1:0] LIGHT_RED    = 2'b10;

   typedef enum logic [2:0] {
      INIT = 3'd0,
      HG   = 3'd1,
      HY   = 3'd2,
      FG   = 3'd3,
      FY   = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       st_q, st_d;
   logic [1:0] hl_q, hl_d;
   logic [1:0] fl_q, fl_d;
   logic       cs1_q, cs1_d;
   logic       cs_q, cs_d;
   logic       tlq, tsq;
   logic       settled;

   // Next-state, timer-start and light decode; lights follow the next state so
   // the registered codes always match the state register with no input path.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no branch
      // can leave one unassigned and infer a latch.
      state_d = state_q;
      hl_d    = LIGHT_RED;
      fl_d    = LIGHT_RED;

      // Two-flop synchronizer for the asynchronous car sensor.
      cs1_d = c;
      cs_d  = cs1_q;

      // A timeout seen while the clear pulse is still in flight is stale.
      settled = ~st_q;
      tlq     = tl & settled;
      tsq     = ts & settled;

      unique case (state_q)
         INIT:    state_d = HG;
         HG:      if (cs_q && tlq)                 state_d = HY;
         HY:      if (tsq)                         state_d = FG;
         // A departed car only ends farm green once the timers have settled.
         FG:      if (settled && (!cs_q || tlq))   state_d = FY;
         FY:      if (tsq)                         state_d = HG;
         default: state_d = INIT;
      endcase

      // Timer start is high for exactly the cycle after any state change.
      st_d = (state_d != state_q);

      unique case (state_d)
         HG: begin
            hl_d = LIGHT_GREEN;
            fl_d = LIGHT_RED;
         end
         HY: begin
            hl_d = LIGHT_YELLOW;
            fl_d = LIGHT_RED;
         end
         FG: begin
            hl_d = LIGHT_RED;
            fl_d = LIGHT_GREEN;
         end
         FY: begin
            hl_d = LIGHT_RED;
            fl_d = LIGHT_YELLOW;
         end
         default: begin
            hl_d = LIGHT_RED;
            fl_d = LIGHT_RED;
         end
      endcase
   end

   // State, registered outputs and synchronizer; reset forces all-red with st
   // held high so both timers are cleared before highway green is entered.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others regardless of statement order.
      if (rst) begin
         state_q <= INIT;
         st_q    <= 1'b1;
         hl_q    <= LIGHT_RED;
         fl_q    <= LIGHT_RED;
         cs1_q   <= 1'b0;
         cs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         hl_q    <= hl_d;
         fl_q    <= fl_d;
         cs1_q   <= cs1_d;
         cs_q    <= cs_d;
      end
   end

   assign st = st_q;
   assign hl = hl_q;
   assign fl = fl_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm. Each stimulus step drives inputs
// just after a falling edge and queues the outputs expected after the next
// rising edge; the monitor pops and compares on every falling edge.
module tb_traffic_light_fsm;

   localparam logic [1:0] G = 2'b00;
   localparam logic [1:0] Y = 2'b01;
   localparam logic [1:0] R = 2'b10;

   typedef enum {S_INIT, S_HG, S_HY, S_FG, S_FY} exp_state_t;

   typedef struct {
      logic [1:0] hl;
      logic [1:0] fl;
      logic       st;
      string      nm;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       c;
   logic       tl;
   logic       ts;
   logic       st;
   logic [1:0] hl;
   logic [1:0] fl;

   exp_t sb_q[$];
   int   n_pass;
   int   n_total;

   traffic_light_fsm dut (
      .clk (clk),
      .rst (rst),
      .c   (c),
      .tl  (tl),
      .ts  (ts),
      .st  (st),
      .hl  (hl),
      .fl  (fl)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hand table of light codes for each state.
   function automatic logic [3:0] lights(input exp_state_t s);
      case (s)
         S_INIT:  return {R, R};
         S_HG:    return {G, R};
         S_HY:    return {Y, R};
         S_FG:    return {R, G};
         S_FY:    return {R, Y};
         default: return 4'b1111;
      endcase
   endfunction

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic step(input logic r, input logic cc, input logic l, input logic s,
                       input exp_state_t es, input logic est, input string nm);
      logic [3:0] lt;
      exp_t       e;
      @(negedge clk);
      #1;
      rst = r;
      c   = cc;
      tl  = l;
      ts  = s;
      lt   = lights(es);
      e.hl = lt[3:2];
      e.fl = lt[1:0];
      e.st = est;
      e.nm = nm;
      sb_q.push_back(e);
   endtask

   // Release reset just after a rising edge so INIT is held for a full cycle.
   task automatic release_rst();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Assert reset between edges and expect all-red with st=1 before the next edge.
   task automatic reset_mid();
      exp_t e;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst  = 1'b1;
      e.hl = R;
      e.fl = R;
      e.st = 1'b1;
      e.nm = "async_rst";
      sb_q.push_back(e);
   endtask

   // Monitor: compare the DUT outputs against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_total++;
            if (hl === e.hl && fl === e.fl && st === e.st)
               n_pass++;
            else
               $display("FAIL %s: got hl=%b fl=%b st=%b, expected hl=%b fl=%b st=%b",
                        e.nm, hl, fl, st, e.hl, e.fl, e.st);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst = 1'b1;
      c   = 1'b0;
      tl  = 1'b0;
      ts  = 1'b0;

      // Reset release: one INIT cycle, then HG with st still high.
      step(1, 0, 0, 0, S_INIT, 1, "rst_init");
      release_rst();
      step(0, 0, 0, 0, S_HG, 1, "first_hg");

      // Idle highway: no car, tl pulses are ignored.
      for (int i = 0; i < 100; i++)
         step(0, 0, (i % 10 == 3), 0, S_HG, 0, "idle_hg");

      // Full cycle with c held high; tl/ts follow 8-count timer behaviour.
      step(0, 1, 0, 0, S_HG, 0, "sync1");
      step(0, 1, 0, 0, S_HG, 0, "sync2");
      step(0, 1, 1, 0, S_HY, 1, "hg_to_hy");
      step(0, 1, 1, 1, S_HY, 0, "stale_ts_hy");
      for (int i = 0; i < 7; i++)
         step(0, 1, 0, 0, S_HY, 0, "hy_wait");
      step(0, 1, 0, 1, S_FG, 1, "hy_to_fg");
      step(0, 1, 1, 1, S_FG, 0, "stale_tl_fg");
      for (int i = 0; i < 7; i++)
         step(0, 1, 0, 0, S_FG, 0, "fg_wait");
      step(0, 1, 1, 0, S_FY, 1, "fg_to_fy_tl");
      step(0, 1, 1, 1, S_FY, 0, "stale_ts_fy");
      for (int i = 0; i < 3; i++)
         step(0, 1, 0, 0, S_FY, 0, "fy_wait");
      step(0, 1, 0, 1, S_HG, 1, "fy_to_hg");
      step(0, 1, 0, 0, S_HG, 0, "hg_settle");

      // Early departure: FY exactly three edges after c falls.
      step(0, 1, 1, 0, S_HY, 1, "hg_to_hy2");
      step(0, 1, 0, 1, S_HY, 0, "hy_hold2");
      step(0, 1, 0, 1, S_FG, 1, "hy_to_fg2");
      step(0, 1, 0, 0, S_FG, 0, "fg_settle");
      step(0, 0, 0, 0, S_FG, 0, "depart_e1");
      step(0, 0, 0, 0, S_FG, 0, "depart_e2");
      step(0, 0, 0, 0, S_FY, 1, "depart_e3");
      step(0, 0, 0, 0, S_FY, 0, "fy_settle");
      step(0, 0, 0, 1, S_HG, 1, "fy_to_hg2");
      step(0, 0, 0, 0, S_HG, 0, "hg_settle2");

      // Mid-operation reset in FG.
      step(0, 1, 0, 0, S_HG, 0, "sync1b");
      step(0, 1, 0, 0, S_HG, 0, "sync2b");
      step(0, 1, 1, 0, S_HY, 1, "hg_to_hy3");
      step(0, 1, 0, 1, S_HY, 0, "hy_hold3");
      step(0, 1, 0, 1, S_FG, 1, "hy_to_fg3");
      step(0, 1, 0, 0, S_FG, 0, "fg_before_rst");
      reset_mid();
      step(1, 0, 0, 0, S_INIT, 1, "rst_held");
      release_rst();
      step(0, 0, 0, 0, S_HG, 1, "post_rst_hg1");
      step(0, 0, 1, 0, S_HG, 0, "post_rst_hg2");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 4 && sb_q.size() > 0; i++)
         @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
